// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and elaboration-time helpers for the iterative CORDIC engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package cordic_pkg;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_COMP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Two guard bits absorb the ~1.647 CORDIC gain plus the sqrt(2) diagonal growth.
    localparam int GUARD_BITS = 2;

    // Shift taps approximating 1/K = 0.6074: 2^-1 + 2^-3 - 2^-6 - 2^-9
    localparam int COMP_SH0 = 1;
    localparam int COMP_SH1 = 3;
    localparam int COMP_SH2 = 6;
    localparam int COMP_SH3 = 9;

    // Fixed-point fraction used while generating the arctangent table.
    localparam int ATAN_FRAC = 60;

    function automatic int iw_of(input int w);
        return w + GUARD_BITS;
    endfunction

    // atan(1/n) * 2^ATAN_FRAC by Taylor series; converges quickly for n >= 2.
    function automatic logic [63:0] atan_inv(input logic [63:0] n);
        logic [63:0] p;
        logic [63:0] acc;
        p   = (64'd1 << ATAN_FRAC) / n;
        acc = '0;
        for (int k = 0; k < 48; k++) begin
            if (k[0] == 1'b0) acc = acc + p / 64'(2 * k + 1);
            else              acc = acc - p / 64'(2 * k + 1);
            // two divides instead of n*n keeps large n from overflowing
            p = p / n;
            p = p / n;
        end
        return acc;
    endfunction

    // round(atan(2^-i) * 2^(w-2)); atan(1) comes from Machin's formula.
    function automatic logic [63:0] atan_lut(input int i, input int w);
        logic [63:0] a;
        if (i == 0) a = 64'd4 * atan_inv(64'd5) - atan_inv(64'd239);
        else        a = atan_inv(64'd1 << i);
        return (a + (64'd1 << (61 - w))) >> (62 - w);
    endfunction

    // Gain compensation on a sign-extended operand; callers truncate back to IW.
    function automatic logic signed [63:0] gain_comp(input logic signed [63:0] v);
        return (v >>> COMP_SH0) + (v >>> COMP_SH1) - (v >>> COMP_SH2) - (v >>> COMP_SH3);
    endfunction

endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one CORDIC micro-rotation (x, y, theta) by shift index i and direction d.
// Latency: combinational; the caller registers the result.
// Backpressure: none (pure datapath).
module cordic_microrot #(
    parameter int IW = 14,
    parameter int SW = 4
) (
    input  logic signed [IW-1:0] i_x,
    input  logic signed [IW-1:0] i_y,
    input  logic signed [IW-1:0] i_z,
    input  logic        [SW-1:0] i_shift,
    input  logic                 i_dir_pos,
    input  logic signed [IW-1:0] i_atan,
    output logic signed [IW-1:0] o_x,
    output logic signed [IW-1:0] o_y,
    output logic signed [IW-1:0] o_z
);

    logic signed [IW-1:0] w_xs;
    logic signed [IW-1:0] w_ys;

    assign w_xs = i_x >>> i_shift;
    assign w_ys = i_y >>> i_shift;

    // d=+1 turns the vector clockwise and adds the angle; d=-1 does the opposite
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (i_dir_pos) begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + i_atan;
        end else begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - i_atan;
        end
    end

endmodule

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC, rotation or vectoring per request, one micro-rotation per cycle.
// Latency: accept on edge E -> out_valid after edge E+ITER (E+ITER+1 when CORDIC_GAIN_COMP_EN adds the 1/K cycle).
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready low outside IDLE.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int W    = 12,
    parameter int ITER = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] theta_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] theta_out
);

    localparam int IW  = iw_of(W);
    localparam int SW  = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int TAB = 1 << SW;

    localparam logic signed [IW-1:0] SAT_HI = IW'((1 << (W - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_LO = IW'(-(1 << (W - 1)));

    logic [1:0]           r_state;
    logic [SW-1:0]        r_iter;
    logic                 r_mode;
    logic signed [IW-1:0] r_x;
    logic signed [IW-1:0] r_y;
    logic signed [IW-1:0] r_z;

    logic signed [IW-1:0] w_atan_tab [TAB];
    logic signed [IW-1:0] w_nx;
    logic signed [IW-1:0] w_ny;
    logic signed [IW-1:0] w_nz;
    logic                 w_dir_pos;

    // Arctangent ROM resolved at elaboration; entries past ITER-1 are never addressed.
    for (genvar gi = 0; gi < TAB; gi++) begin : g_atan
        localparam logic [63:0] ATAN_VAL = (gi < ITER) ? atan_lut(gi, W) : 64'd0;
        assign w_atan_tab[gi] = ATAN_VAL[IW-1:0];
    end

    // Vectoring chases y to zero, rotation chases theta to zero.
    assign w_dir_pos = r_mode ? ~r_y[IW-1] : r_z[IW-1];

    cordic_microrot #(
        .IW (IW),
        .SW (SW)
    ) u_microrot (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_z       (r_z),
        .i_shift   (r_iter),
        .i_dir_pos (w_dir_pos),
        .i_atan    (w_atan_tab[r_iter]),
        .o_x       (w_nx),
        .o_y       (w_ny),
        .o_z       (w_nz)
    );

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [IW-1:0] w_cx;
    logic signed [IW-1:0] w_cy;
    assign w_cx = IW'(gain_comp(64'(r_x)));
    assign w_cy = IW'(gain_comp(64'(r_y)));
`endif

    function automatic logic signed [W-1:0] sat(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] c;
        if (v > SAT_HI)      c = SAT_HI;
        else if (v < SAT_LO) c = SAT_LO;
        else                 c = v;
        return c[W-1:0];
    endfunction

    // Request load, per-cycle micro-rotation, optional scaling, and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_iter  <= '0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x     <= {{GUARD_BITS{x_in[W-1]}}, x_in};
                        r_y     <= {{GUARD_BITS{y_in[W-1]}}, y_in};
                        r_z     <= {{GUARD_BITS{theta_in[W-1]}}, theta_in};
                        r_mode  <= mode;
                        r_iter  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                    r_z <= w_nz;
                    if (r_iter == SW'(ITER - 1)) begin
                        r_iter <= '0;
`ifdef CORDIC_GAIN_COMP_EN
                        r_state <= ST_COMP;
`else
                        r_state <= ST_DONE;
`endif
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                ST_COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
                    r_x     <= w_cx;
                    r_y     <= w_cy;
                    r_state <= ST_DONE;
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign x_out     = sat(r_x);
    assign y_out     = sat(r_y);
    assign theta_out = sat(r_z);

endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed vector table plus backpressure, mid-run reset and back-to-back sequences.
// Latency: checks out_valid edge count against ITER (ITER+1 with CORDIC_GAIN_COMP_EN).
// Backpressure: holds out_ready low in DONE and checks the result stays put with in_ready low.
module tb_cordic_iter;

    localparam int W    = 12;
    localparam int ITER = 12;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = ITER + 1;
`else
    localparam int LAT  = ITER;
`endif
    localparam int SPACING = LAT + 2;
    localparam int NV      = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] theta_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;
    logic signed [W-1:0] theta_out;

    cordic_iter #(.W(W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .theta_in  (theta_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .theta_out (theta_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic mode;
        int   x;
        int   y;
        int   z;
        int   ex;
        int   ey;
        int   ez;
        int   tol;
        bit   chk_y;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   acc [3];
    int   nacc;
    int   guard;

    function automatic vec_t mk(input logic m, input int x, input int y, input int z,
                                input int ex, input int ey, input int ez, input int tol, input bit cy);
        vec_t v;
        v.mode = m; v.x = x; v.y = y; v.z = z;
        v.ex = ex; v.ey = ey; v.ez = ez; v.tol = tol; v.chk_y = cy;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Called at a negedge with the engine idle; returns at the negedge after acceptance.
    task automatic send(input vec_t v, input string name);
        chk({name, "_in_ready"}, int'(in_ready), 1, 0);
        mode     = v.mode;
        x_in     = v.x[W-1:0];
        y_in     = v.y[W-1:0];
        theta_in = v.z[W-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges since acceptance until out_valid; bounded, checks handshake exclusivity on the way.
    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            checks++;
            if (out_valid && in_ready) begin
                errors++;
                $display("FAIL excl: out_valid=%0b in_ready=%0b both high", out_valid, in_ready);
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_result(input vec_t v, input string name);
        chk({name, "_x"}, int'(x_out), v.ex, v.tol);
        if (v.chk_y) chk({name, "_y"}, int'(y_out), v.ey, v.tol);
        chk({name, "_theta"}, int'(theta_out), v.ez, v.tol);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
`ifdef CORDIC_GAIN_COMP_EN
        vecs[0] = mk(1'b1,  1000,     0,    0,  1000,    0,    0, 4, 1'b1);
        vecs[1] = mk(1'b1,  1000,  1000,    0,  1414,    0,  804, 4, 1'b1);
        vecs[2] = mk(1'b1,  1000, -1000,    0,  1414,    0, -804, 4, 1'b1);
        vecs[3] = mk(1'b0,  1000,     0,  536,   866,  500,    0, 4, 1'b1);
        vecs[4] = mk(1'b0,  1000,     0, -536,   866, -500,    0, 4, 1'b1);
        vecs[5] = mk(1'b0, -2000,     0,    0, -2000,    0,    0, 8, 1'b0);
`else
        vecs[0] = mk(1'b1,  1000,     0,    0,  1647,    0,    0, 4, 1'b1);
        vecs[1] = mk(1'b1,  1000,  1000,    0,  2047,    0,  804, 4, 1'b1);
        vecs[2] = mk(1'b1,  1000, -1000,    0,  2047,    0, -804, 4, 1'b1);
        vecs[3] = mk(1'b0,  1000,     0,  536,  1426,  823,    0, 4, 1'b1);
        vecs[4] = mk(1'b0,  1000,     0, -536,  1426, -823,    0, 4, 1'b1);
        vecs[5] = mk(1'b0, -2000,     0,    0, -2048,    0,    0, 4, 1'b0);
`endif

        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
        x_in = '0; y_in = '0; theta_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_x_out",     int'(x_out),     0, 0);
        chk("rst_y_out",     int'(y_out),     0, 0);
        chk("rst_theta_out", int'(theta_out), 0, 0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            send(vecs[i], $sformatf("v%0d", i));
            wait_out(lat);
            chk($sformatf("v%0d_latency", i), lat, LAT, 0);
            chk_result(vecs[i], $sformatf("v%0d", i));
            @(negedge clk);
            chk($sformatf("v%0d_idle_ready", i), int'(in_ready), 1, 0);
            chk($sformatf("v%0d_idle_valid", i), int'(out_valid), 0, 0);
        end

        // Backpressure: hold DONE for 5 cycles with a pending request upstream
        out_ready = 1'b0;
        send(vecs[3], "bp");
        wait_out(lat);
        chk("bp_latency", lat, LAT, 0);
        mode = vecs[0].mode; x_in = vecs[0].x[W-1:0]; y_in = vecs[0].y[W-1:0]; theta_in = vecs[0].z[W-1:0];
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_out_valid", k), int'(out_valid), 1, 0);
            chk($sformatf("bp%0d_in_ready", k), int'(in_ready), 0, 0);
            chk_result(vecs[3], $sformatf("bp%0d", k));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  int'(in_ready),  1, 0);
        chk("bp_release_out_valid", int'(out_valid), 0, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp_next_latency", lat, LAT, 0);
        chk_result(vecs[0], "bp_next");
        @(negedge clk);

        // Reset while RUN is at iteration 5
        send(vecs[3], "mr");
        repeat (5) @(negedge clk);
        chk("mr_running", int'(out_valid), 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_out_valid", int'(out_valid), 0, 0);
        chk("mr_in_ready",  int'(in_ready),  1, 0);
        chk("mr_x_out",     int'(x_out),     0, 0);
        chk("mr_y_out",     int'(y_out),     0, 0);
        chk("mr_theta_out", int'(theta_out), 0, 0);
        send(vecs[4], "mr_fresh");
        wait_out(lat);
        chk("mr_fresh_latency", lat, LAT, 0);
        chk_result(vecs[4], "mr_fresh");
        @(negedge clk);

        // Back-to-back requests with out_ready high
        mode = vecs[0].mode; x_in = vecs[0].x[W-1:0]; y_in = vecs[0].y[W-1:0]; theta_in = vecs[0].z[W-1:0];
        in_valid = 1'b1;
        nacc = 0; guard = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        while (nacc < 3 && guard < 200) begin
            if (in_ready) begin
                acc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("b2b_accept_count", nacc, 3, 0);
        chk("b2b_spacing_0", acc[1] - acc[0], SPACING, 0);
        chk("b2b_spacing_1", acc[2] - acc[1], SPACING, 0);
        wait_out(lat);
        chk_result(vecs[0], "b2b_last");
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
